// File: rtl/sfx_pkg.sv
// ---------------------------------------------------------------------------
// sfx_pkg
//   Shared definitions for the sound-effect sequencer:
//     - effect identifiers (index = priority, higher wins)
//     - note_t : one table entry {half_period, duration}
//     - state_t: sequencer FSM encoding
//     - sfx_note()      : the game's note table (25.125 MHz pixel clock)
//     - sfx_test_note() : short-period table used for simulation
//     - id_width()      : index width helper, never narrower than 1 bit
//   No ports (package).
// ---------------------------------------------------------------------------
package sfx_pkg;

    localparam int NOTE_HALF_W = 16;
    localparam int NOTE_DUR_W  = 8;

    localparam int SFX_JUMP_FWD   = 0;
    localparam int SFX_JUMP_BACK  = 1;
    localparam int SFX_JUMP_RIGHT = 2;
    localparam int SFX_JUMP_LEFT  = 3;
    localparam int SFX_WIN        = 4;
    localparam int SFX_LOSE       = 5;

    typedef struct packed {
        logic [NOTE_HALF_W-1:0] half_period;
        logic [NOTE_DUR_W-1:0]  duration;
    } note_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PLAY = 2'd2
    } state_t;

    function automatic int id_width(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic note_t mk_note(int half_period, int duration);
        note_t n;
        n.half_period = NOTE_HALF_W'(half_period);
        n.duration    = NOTE_DUR_W'(duration);
        return n;
    endfunction

    // Half periods are clk cycles at 25.125 MHz: 25_125_000 / (2 * f_note).
    // A zero half period is a rest; a zero duration ends the effect early.
    function automatic note_t sfx_note(int id, int idx);
        note_t n;
        n = '0;
        case (id)
            SFX_JUMP_FWD: case (idx)     // C5 E5 G5
                0: n = mk_note(24008, 60);
                1: n = mk_note(19056, 60);
                2: n = mk_note(16024, 80);
                default: n = '0;
            endcase
            SFX_JUMP_BACK: case (idx)    // G5 E5 C5
                0: n = mk_note(16024, 60);
                1: n = mk_note(19056, 60);
                2: n = mk_note(24008, 80);
                default: n = '0;
            endcase
            SFX_JUMP_RIGHT: case (idx)   // E5 G5
                0: n = mk_note(19056, 50);
                1: n = mk_note(16024, 50);
                default: n = '0;
            endcase
            SFX_JUMP_LEFT: case (idx)    // G5 E5
                0: n = mk_note(16024, 50);
                1: n = mk_note(19056, 50);
                default: n = '0;
            endcase
            SFX_WIN: case (idx)          // C5 E5 G5 C6
                0: n = mk_note(24008, 120);
                1: n = mk_note(19056, 120);
                2: n = mk_note(16024, 120);
                3: n = mk_note(12004, 250);
                default: n = '0;
            endcase
            SFX_LOSE: case (idx)         // G4 rest F4 C4
                0: n = mk_note(32047, 150);
                1: n = mk_note(0,     50);
                2: n = mk_note(35972, 150);
                3: n = mk_note(48017, 250);
                default: n = '0;
            endcase
            default: n = '0;
        endcase
        return n;
    endfunction

    // Short periods so a whole effect fits in a few dozen cycles at a
    // 10 cycles-per-ms tick.
    function automatic note_t sfx_test_note(int id, int idx);
        note_t n;
        n = '0;
        if (id == 0) begin
            case (idx)
                0: n = mk_note(4, 2);
                1: n = mk_note(0, 1);
                2: n = mk_note(2, 1);
                default: n = '0;
            endcase
        end else begin
            case (idx)
                0: n = mk_note(id + 1, 3);
                1: n = mk_note(0, 1);
                2: n = mk_note(id + 2, 2);
                3: n = mk_note(3, 1);
                default: n = '0;
            endcase
        end
        return n;
    endfunction

endpackage

// File: rtl/sfx_sequencer_if.sv
// ---------------------------------------------------------------------------
// sfx_sequencer_if
//   Game-logic side of the sound-effect sequencer.
//     enable  : global sound enable (0 = mute and abort)
//     trigger : NUM_SFX asynchronous level requests, rising edge = request
//     busy    : an effect is playing
//     sfx_id  : index of the effect playing (valid while busy)
//     sound   : square-wave audio pin
//   master = game logic / buttons, slave = sequencer.
// ---------------------------------------------------------------------------
interface sfx_sequencer_if
    import sfx_pkg::*;
#(
    parameter int NUM_SFX = 6
);
    localparam int ID_W = id_width(NUM_SFX);

    logic               enable;
    logic [NUM_SFX-1:0] trigger;
    logic               busy;
    logic [ID_W-1:0]    sfx_id;
    logic               sound;

    modport master (
        output enable,
        output trigger,
        input  busy,
        input  sfx_id,
        input  sound
    );

    modport slave (
        input  enable,
        input  trigger,
        output busy,
        output sfx_id,
        output sound
    );

endinterface

// File: rtl/sfx_tone_gen.sv
// ---------------------------------------------------------------------------
// sfx_tone_gen
//   Square-wave generator: counts 0..half_period-1 and toggles the output
//   on each wrap. A zero half period is a rest and holds the output low.
//     clk, rst_n  : clock, asynchronous active-low reset
//     clear       : zero the counter and force the output low
//     half_period : half period in clk cycles
//     sound       : registered square-wave output
// ---------------------------------------------------------------------------
module sfx_tone_gen #(
    parameter int HALF_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic [HALF_W-1:0] half_period,
    output logic              sound
);

    logic [HALF_W-1:0] tone_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tone_cnt <= '0;
            sound    <= 1'b0;
        end else if (clear || half_period == '0) begin
            tone_cnt <= '0;
            sound    <= 1'b0;
        end else if (tone_cnt == half_period - HALF_W'(1)) begin
            tone_cnt <= '0;
            sound    <= ~sound;
        end else begin
            tone_cnt <= tone_cnt + HALF_W'(1);
        end
    end

endmodule

// File: rtl/sfx_sequencer.sv
// ---------------------------------------------------------------------------
// sfx_sequencer
//   Plays the highest-priority triggered sound effect as a sequence of
//   square-wave notes from a constant note table. A higher-index request
//   restarts playback at that effect; equal or lower ones are dropped.
//     clk, rst_n : pixel clock, asynchronous active-low reset
//     bus        : sfx_sequencer_if.slave (enable, trigger in;
//                  busy, sfx_id, sound out)
//   TEST_TABLE selects the short simulation note table.
// ---------------------------------------------------------------------------
module sfx_sequencer
    import sfx_pkg::*;
#(
    parameter int CLK_FREQ_HZ   = 25_125_000,
    parameter int NUM_SFX       = 6,
    parameter int NOTES_PER_SFX = 4,
    parameter int HALF_W        = 16,
    parameter int DUR_W         = 8,
    parameter bit TEST_TABLE    = 1'b0
) (
    input  logic           clk,
    input  logic           rst_n,
    sfx_sequencer_if.slave bus
);

    localparam int ID_W  = id_width(NUM_SFX);
    localparam int IDX_W = id_width(NOTES_PER_SFX);
    localparam int TICK  = CLK_FREQ_HZ / 1000;
    localparam int PRE_W = (TICK > 1) ? $clog2(TICK) : 1;

    // -------------------------------------------------------------------
    // Trigger synchronisers and edge detect (run even while disabled, so a
    // trigger held across enable rising never looks like a new edge)
    // -------------------------------------------------------------------
    logic [NUM_SFX-1:0] trig_p0, trig_p1, trig_p2, req_p3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_p0 <= '0;
            trig_p1 <= '0;
            trig_p2 <= '0;
            req_p3  <= '0;
        end else begin
            trig_p0 <= bus.trigger;
            trig_p1 <= trig_p0;
            trig_p2 <= trig_p1;
            req_p3  <= trig_p1 & ~trig_p2;
        end
    end

    // Priority arbitration: the loop lets the highest set index win.
    logic            req_any;
    logic [ID_W-1:0] req_win;

    always_comb begin
        req_any = |req_p3;
        req_win = '0;
        for (int i = 0; i < NUM_SFX; i++) begin
            if (req_p3[i]) req_win = ID_W'(i);
        end
    end

    // -------------------------------------------------------------------
    // Sequencer state and datapath registers
    // -------------------------------------------------------------------
    state_t            state, state_nxt;
    logic [ID_W-1:0]   sfx_id_r;
    logic [IDX_W-1:0]  note_idx;
    logic [HALF_W-1:0] half_period;
    logic [DUR_W-1:0]  dur_cnt;
    logic [PRE_W-1:0]  prescale;

    note_t cur_note;
    logic  tick, preempt, note_zero, note_done, last_note;

    always_comb begin
        if (TEST_TABLE) cur_note = sfx_test_note(int'(sfx_id_r), int'(note_idx));
        else            cur_note = sfx_note(int'(sfx_id_r), int'(note_idx));
    end

    assign tick      = (prescale == PRE_W'(TICK - 1));
    assign preempt   = req_any && (req_win > sfx_id_r);
    assign note_zero = (cur_note.duration == '0);
    // The duration counter reaches zero on this tick.
    assign note_done = tick && (dur_cnt == DUR_W'(1));
    assign last_note = (note_idx == IDX_W'(NOTES_PER_SFX - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (req_any) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                if (preempt)        state_nxt = ST_LOAD;
                else if (note_zero) state_nxt = ST_IDLE;
                else                state_nxt = ST_PLAY;
            end
            ST_PLAY: begin
                if (preempt)        state_nxt = ST_LOAD;
                else if (note_done) state_nxt = last_note ? ST_IDLE : ST_LOAD;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (!bus.enable) state_nxt = ST_IDLE;
    end

    logic busy, start_fx, adv_note, load_note, run, tone_clear;

    always_comb begin
        busy      = (state != ST_IDLE);
        // New effect: from idle, or a higher-priority restart.
        start_fx  = (state_nxt == ST_LOAD) && ((state == ST_IDLE) || preempt);
        adv_note  = (state == ST_PLAY) && (state_nxt == ST_LOAD) && !preempt;
        load_note = (state == ST_LOAD);
        run       = (state == ST_PLAY);
        // Silence on every edge that leaves PLAY or is not yet in PLAY, so
        // entering IDLE or LOAD drops the pin in the same cycle and a new
        // note always starts its half period from a cleared counter.
        tone_clear = (state != ST_PLAY) || (state_nxt != ST_PLAY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sfx_id_r    <= '0;
            note_idx    <= '0;
            half_period <= '0;
            dur_cnt     <= '0;
            prescale    <= '0;
        end else begin
            if (start_fx) begin
                sfx_id_r <= req_win;
                note_idx <= '0;
            end else if (adv_note) begin
                note_idx <= note_idx + IDX_W'(1);
            end

            if (load_note) begin
                half_period <= HALF_W'(cur_note.half_period);
                dur_cnt     <= DUR_W'(cur_note.duration);
                prescale    <= '0;
            end else if (run) begin
                if (tick) begin
                    prescale <= '0;
                    dur_cnt  <= dur_cnt - DUR_W'(1);
                end else begin
                    prescale <= prescale + PRE_W'(1);
                end
            end
        end
    end

    // -------------------------------------------------------------------
    // Tone generation and outputs
    // -------------------------------------------------------------------
    logic sound;

    sfx_tone_gen #(
        .HALF_W (HALF_W)
    ) u_tone (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (tone_clear),
        .half_period (half_period),
        .sound       (sound)
    );

    assign bus.busy   = busy;
    assign bus.sfx_id = sfx_id_r;
    assign bus.sound  = sound;

endmodule

// File: tb/tb_sfx_sequencer.sv
module tb_sfx_sequencer;

    localparam int N_SFX = 6;
    localparam int NOTES = 4;
    localparam int TICK  = 10;
    localparam int NCYC  = 5200;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    sfx_sequencer_if #(.NUM_SFX(N_SFX)) bus ();

    sfx_sequencer #(
        .CLK_FREQ_HZ   (10_000),
        .NUM_SFX       (N_SFX),
        .NOTES_PER_SFX (NOTES),
        .HALF_W        (16),
        .DUR_W         (8),
        .TEST_TABLE    (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Stimulus per cycle: applied just after the negedge of cycle c.
    logic [N_SFX-1:0] trig_a [NCYC];
    bit               en_a   [NCYC];
    bit               rst_a  [NCYC];

    // Expected output of every effect, indexed by cycles since its first LOAD.
    bit tl_snd [N_SFX][200];
    int tl_len [N_SFX];

    typedef struct {
        int cyc;
        bit busy;
        int id;
        bit snd;
    } ev_t;
    ev_t expq[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Independent copy of the simulation note table.
    task automatic tb_note(input int id, input int idx, output int hp, output int dur);
        if (id == 0) begin
            case (idx)
                0: begin hp = 4; dur = 2; end
                1: begin hp = 0; dur = 1; end
                2: begin hp = 2; dur = 1; end
                default: begin hp = 0; dur = 0; end
            endcase
        end else begin
            case (idx)
                0: begin hp = id + 1; dur = 3; end
                1: begin hp = 0;      dur = 1; end
                2: begin hp = id + 2; dur = 2; end
                default: begin hp = 3; dur = 1; end
            endcase
        end
    endtask

    // One LOAD cycle (silent) per note, then dur ms of square wave whose
    // level is floor(k / half) mod 2; a zero-duration note ends the effect.
    task automatic build_timelines();
        int off, hp, dur;
        for (int id = 0; id < N_SFX; id++) begin
            off = 0;
            for (int idx = 0; idx < NOTES; idx++) begin
                tb_note(id, idx, hp, dur);
                tl_snd[id][off] = 1'b0;
                off++;
                if (dur == 0) break;
                for (int k = 0; k < dur * TICK; k++)
                    tl_snd[id][off + k] = (hp == 0) ? 1'b0 : (((k / hp) % 2) == 1);
                off += dur * TICK;
            end
            tl_len[id] = off;
        end
    endtask

    function automatic void pulse(int b, int from, int to);
        for (int c = from; c < to && c < NCYC; c++) trig_a[c][b] = 1'b1;
    endfunction

    function automatic void hold_off(int from, int to);
        for (int c = from; c < to && c < NCYC; c++) en_a[c] = 1'b0;
    endfunction

    task automatic build_stimulus();
        int c, kind, b1, b2, len;
        for (int i = 0; i < NCYC; i++) begin
            trig_a[i] = '0;
            en_a[i]   = 1'b1;
            rst_a[i]  = 1'b0;
        end
        // Reset held while triggers toggle, quiet before release.
        for (int i = 0; i < 20; i++) rst_a[i] = 1'b1;
        for (int i = 0; i < 16; i++) trig_a[i] = N_SFX'($urandom);
        // Single play of effect 0.
        pulse(0, 30, 35);
        // Simultaneous 1 and 4.
        pulse(1, 100, 104);
        pulse(4, 100, 104);
        // Preemption by 5, then a lower request that must be ignored.
        pulse(2, 200, 203);
        pulse(5, 220, 226);
        pulse(3, 240, 244);
        // Enable drop mid-note; pulse while disabled; trigger held across enable.
        pulse(1, 320, 323);
        hold_off(340, 370);
        pulse(2, 350, 353);
        pulse(3, 360, 401);
        // Held trigger: one play, second only after a low-then-high edge.
        pulse(0, 420, 1420);
        pulse(0, 1430, 1436);
        // Reset in the middle of an effect.
        pulse(5, 1500, 1503);
        for (int i = 1530; i < 1535; i++) rst_a[i] = 1'b1;
        // Random phase.
        c = 1600;
        while (c < NCYC - 150) begin
            c += int'($urandom_range(3, 40));
            kind = int'($urandom_range(0, 7));
            b1   = int'($urandom_range(0, N_SFX - 1));
            b2   = int'($urandom_range(0, N_SFX - 1));
            len  = int'($urandom_range(1, 8));
            if (kind <= 4) begin
                pulse(b1, c, c + len);
            end else if (kind <= 6) begin
                pulse(b1, c, c + len);
                pulse(b2, c, c + len);
            end else begin
                hold_off(c, c + int'($urandom_range(1, 30)));
            end
        end
    endtask

    function automatic logic [N_SFX-1:0] teff(int n);
        return rst_a[n] ? '0 : trig_a[n];
    endfunction

    // Behavioural model: a rising trigger level at cycle n is a request acted
    // on at cycle n+4; the effect then follows its timeline unless cut short.
    task automatic run_model();
        bit playing, lb, ls, ob, os, bprev;
        int cur, start, lid, oid, n, w;
        logic [N_SFX-1:0] rq;
        playing = 1'b0; cur = 0; start = 0;
        lb = 1'b0; ls = 1'b0; lid = 0;
        for (int c = 1; c <= NCYC; c++) begin
            ob = 1'b0; os = 1'b0; oid = 0;
            if (rst_a[c - 1]) begin
                playing = 1'b0;
            end else begin
                n  = c - 4;
                rq = '0;
                if (n >= 1 && !rst_a[n + 1] && !rst_a[n + 2])
                    rq = teff(n) & ~teff(n - 1);
                bprev = playing && ((c - 1 - start) < tl_len[cur]);
                if (!bprev) playing = 1'b0;
                if (!en_a[c - 1]) begin
                    playing = 1'b0;
                end else if (rq != '0) begin
                    w = 0;
                    for (int i = 0; i < N_SFX; i++) if (rq[i]) w = i;
                    if (!bprev || w > cur) begin
                        playing = 1'b1;
                        cur     = w;
                        start   = c;
                    end
                end
                if (playing && (c - start) < tl_len[cur]) begin
                    ob  = 1'b1;
                    oid = cur;
                    os  = tl_snd[cur][c - start];
                end
            end
            if (ob != lb || os != ls || oid != lid) begin
                expq.push_back('{c, ob, oid, os});
                lb = ob; ls = os; lid = oid;
            end
        end
    endtask

    task automatic apply(input int c);
        bus.trigger = trig_a[c];
        bus.enable  = en_a[c];
        rst_n       = !rst_a[c];
    endtask

    // Monitor: reset state while reset is held, and every change of the
    // (busy, sfx_id when busy, sound) tuple against the expected change list.
    initial begin : monitor
        bit lb, ls, b, s;
        int lid, id;
        ev_t e;
        lb = 1'b0; ls = 1'b0; lid = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                checks++;
                if (bus.busy !== 1'b0 || bus.sfx_id !== '0 || bus.sound !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_state cyc=%0d got busy=%b id=%0d sound=%b want 0 0 0",
                             cyc, bus.busy, bus.sfx_id, bus.sound);
                end
            end
            b  = (bus.busy === 1'b1);
            s  = (bus.sound === 1'b1);
            id = b ? int'(bus.sfx_id) : 0;
            if (b != lb || s != ls || id != lid) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change cyc=%0d got busy=%b id=%0d sound=%b, none expected",
                             cyc, b, id, s);
                end else begin
                    e = expq.pop_front();
                    if (e.cyc != cyc || e.busy != b || e.id != id || e.snd != s) begin
                        errors++;
                        $display("FAIL output_change got cyc=%0d busy=%b id=%0d sound=%b want cyc=%0d busy=%b id=%0d sound=%b",
                                 cyc, b, id, s, e.cyc, e.busy, e.id, e.snd);
                    end
                end
                lb = b; ls = s; lid = id;
            end
        end
    end

    initial begin : driver
        bus.trigger = '0;
        bus.enable  = 1'b1;
        build_timelines();
        build_stimulus();
        run_model();
        #1;
        apply(0);
        for (int c = 1; c < NCYC; c++) begin
            @(negedge clk);
            #1;
            apply(c);
        end
        @(negedge clk);
        #2;
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL missing_changes got %0d unconsumed, want 0 (next cyc=%0d busy=%b id=%0d sound=%b)",
                     expq.size(), expq[0].cyc, expq[0].busy, expq[0].id, expq[0].snd);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
